mux_cfg_loader: RTL and testbench

// - Configuration controller for the CPLD select network: loads the dualmux

---
 rtl/mux_cfg_loader.sv | 171 +++++++++++++++++
 tb/tb_mux_cfg_loader.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_cfg_loader.sv
// mux_cfg_loader: serial configuration loader for the CPLD select network.
// Configuration bits shift LSB-first into a shadow register. The live dualmux
// msel and mux select outputs update together, and only after a complete and
// valid load. Partial, aborted or corrupt loads never reach the routing.
//
// Optional feature, selected by the macro MUX_CFG_PARITY_EN:
//   defined   - one even-parity bit follows the W data bits. A parity
//               mismatch drops the load and sets err.
//   undefined - no parity state is built and err is tied low.
module mux_cfg_loader #(
  parameter int N_MSEL = 8,
  parameter int N_MUX  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic              bit_ready,
  output logic [N_MSEL-1:0] msel,
  output logic [N_MUX-1:0]  muxsel,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // Total bits per load. This is derived from the two widths, so it cannot be overridden.
  localparam int W  = N_MSEL + N_MUX;
  localparam int CW = $clog2(W + 1);

`ifdef MUX_CFG_PARITY_EN
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_PARITY = 2'd2,
    S_COMMIT = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_COMMIT = 2'd3
  } state_t;
`endif

  state_t            state_q;
  logic [CW-1:0]     count_q;
  logic [W-1:0]      shadow_q;
  logic [N_MSEL-1:0] msel_q;
  logic [N_MUX-1:0]  muxsel_q;
  logic              bit_ready_q;
  logic              busy_q;
  logic              done_q;
`ifdef MUX_CFG_PARITY_EN
  logic              err_q;
`endif

  // A bit moves only when both sides agree in the same cycle.
  logic accept;
  assign accept = bit_valid & bit_ready_q;

  // Load sequencer. All outputs come from registers, so the routing never sees a glitch.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the shadow register and the live selects are ordinary flops,
      // not a RAM. Clearing them on reset means a reset during a load
      // leaves no stale routing behind.
      state_q     <= S_IDLE;
      count_q     <= '0;
      shadow_q    <= '0;
      msel_q      <= '0;
      muxsel_q    <= '0;
      bit_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef MUX_CFG_PARITY_EN
      err_q       <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments only. Every branch below reads the
      // values from before the edge, which keeps the FSM order-independent.
      // done is a single-cycle pulse, so it is low unless COMMIT raises it.
      done_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          // start wins over abort here, because abort is not looked at in IDLE.
          if (start) begin
            state_q     <= S_SHIFT;
            count_q     <= '0;
            bit_ready_q <= 1'b1;
            busy_q      <= 1'b1;
`ifdef MUX_CFG_PARITY_EN
            err_q       <= 1'b0;
`endif
          end
        end

        S_SHIFT: begin
          if (abort) begin
            // abort beats a bit accepted in the same cycle.
            state_q     <= S_IDLE;
            bit_ready_q <= 1'b0;
            busy_q      <= 1'b0;
          end else if (accept) begin
            for (int i = 0; i < W; i++) begin
              if (count_q == CW'(i)) shadow_q[i] <= bit_in;
            end
            count_q <= count_q + 1'b1;
            if (count_q == CW'(W - 1)) begin
`ifdef MUX_CFG_PARITY_EN
              state_q     <= S_PARITY;
`else
              state_q     <= S_COMMIT;
              bit_ready_q <= 1'b0;
`endif
            end
          end
        end

`ifdef MUX_CFG_PARITY_EN
        S_PARITY: begin
          if (abort) begin
            state_q     <= S_IDLE;
            bit_ready_q <= 1'b0;
            busy_q      <= 1'b0;
          end else if (accept) begin
            bit_ready_q <= 1'b0;
            // Even parity: the XOR of all W data bits and the parity bit must be 0.
            if ((^shadow_q) ^ bit_in) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              err_q   <= 1'b1;
            end else begin
              state_q <= S_COMMIT;
            end
          end
        end
`endif

        S_COMMIT: begin
          // Both select groups update on the same edge, so the live routing changes atomically.
          msel_q   <= shadow_q[N_MSEL-1:0];
          muxsel_q <= shadow_q[W-1:N_MSEL];
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= S_IDLE;
        end

        default: begin
          state_q     <= S_IDLE;
          bit_ready_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bit_ready = bit_ready_q;
  assign msel      = msel_q;
  assign muxsel    = muxsel_q;
  assign busy      = busy_q;
  assign done      = done_q;
`ifdef MUX_CFG_PARITY_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_mux_cfg_loader.sv
// Testbench for mux_cfg_loader. The stimulus pushes each expected committed
// configuration onto a queue. A monitor pops an entry whenever done pulses
// and compares it with the live selects.
module tb_mux_cfg_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       abort;
  logic       bit_in;
  logic       bit_valid;
  logic       bit_ready;
  logic [7:0] msel;
  logic [7:0] muxsel;
  logic       busy;
  logic       done;
  logic       err;

  int checks = 0;
  int errors = 0;

  // Expected committed configurations: {muxsel, msel}.
  logic [15:0] sb[$];
  logic [15:0] last_cfg;

  mux_cfg_loader #(.N_MSEL(8), .N_MUX(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .bit_ready (bit_ready),
    .msel      (msel),
    .muxsel    (muxsel),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: on every done pulse, pop the next expected configuration.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no commit");
      end else begin
        logic [15:0] exp_cfg;
        exp_cfg = sb.pop_front();
        check("sb_msel", {24'd0, msel}, {24'd0, exp_cfg[7:0]});
        check("sb_muxsel", {24'd0, muxsel}, {24'd0, exp_cfg[15:8]});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic par_of(input logic [15:0] d);
    return ^d;
  endfunction

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    check("bit_ready_before_bit", {31'd0, bit_ready}, 32'd1);
    bit_in    = b;
    bit_valid = 1'b1;
    tick();
  endtask

  // One complete load.
  // gaps:      insert a bit_valid=0 cycle between bits, with a stray start.
  // par:       the parity bit to send (parity build only).
  // ab_commit: assert abort while in COMMIT, where it must be ignored.
  task automatic load(input logic [15:0] data, input logic gaps, input logic par,
                      input logic ab_commit);
    logic ok;
`ifdef MUX_CFG_PARITY_EN
    ok = ~(par_of(data) ^ par);
`else
    ok = 1'b1;
`endif
    if (ok) sb.push_back(data);
    do_start();
    check("start_busy", {31'd0, busy}, 32'd1);
    check("start_err_clear", {31'd0, err}, 32'd0);
    for (int k = 0; k < 16; k++) begin
      send_bit(data[k]);
      if (gaps && k != 15) begin
        bit_valid = 1'b0;
        bit_in    = ~data[k];
        start     = 1'b1;
        tick();
        start     = 1'b0;
      end
    end
`ifdef MUX_CFG_PARITY_EN
    check("parity_busy", {31'd0, busy}, 32'd1);
    send_bit(par);
`endif
    bit_valid = 1'b0;
    if (ok) begin
      check("commit_state_done", {31'd0, done}, 32'd0);
      check("commit_state_busy", {31'd0, busy}, 32'd1);
      check("commit_state_ready", {31'd0, bit_ready}, 32'd0);
      if (ab_commit) abort = 1'b1;
      tick();
      abort = 1'b0;
      check("done_pulse", {31'd0, done}, 32'd1);
      check("idle_busy", {31'd0, busy}, 32'd0);
      check("msel_new", {24'd0, msel}, {24'd0, data[7:0]});
      check("muxsel_new", {24'd0, muxsel}, {24'd0, data[15:8]});
      last_cfg = data;
      tick();
      check("done_one_cycle", {31'd0, done}, 32'd0);
    end else begin
      check("perr_busy", {31'd0, busy}, 32'd0);
      check("perr_err", {31'd0, err}, 32'd1);
      check("perr_done", {31'd0, done}, 32'd0);
      check("perr_ready", {31'd0, bit_ready}, 32'd0);
      check("perr_msel_hold", {24'd0, msel}, {24'd0, last_cfg[7:0]});
      check("perr_muxsel_hold", {24'd0, muxsel}, {24'd0, last_cfg[15:8]});
      tick();
      check("perr_no_done", {31'd0, done}, 32'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] abort_data;
    reset     = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    bit_in    = 1'b0;
    bit_valid = 1'b0;
    last_cfg  = 16'h0000;
    repeat (3) tick();
    reset = 1'b0;
    repeat (5) tick();
    check("rst_msel", {24'd0, msel}, 32'd0);
    check("rst_muxsel", {24'd0, muxsel}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_ready", {31'd0, bit_ready}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);

    // Basic load with bit_valid held high: msel=5A, muxsel=A5.
    load(16'hA55A, 1'b0, par_of(16'hA55A), 1'b0);
    // A different value, with abort asserted in COMMIT (must be ignored).
    load(16'h1234, 1'b0, par_of(16'h1234), 1'b1);
    // Same 0xA55A load with bit_valid toggling and a stray start in each gap.
    load(16'hA55A, 1'b1, par_of(16'hA55A), 1'b0);
    // Load 0x00FF, then abort a new load after 7 bits.
    load(16'h00FF, 1'b0, par_of(16'h00FF), 1'b0);
    abort_data = 16'h3C3C;
    do_start();
    for (int k = 0; k < 7; k++) send_bit(abort_data[k]);
    bit_in    = 1'b1;
    bit_valid = 1'b1;
    abort     = 1'b1;
    tick();
    abort     = 1'b0;
    bit_valid = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_ready", {31'd0, bit_ready}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_msel_hold", {24'd0, msel}, 32'h0000_00FF);
    check("abort_muxsel_hold", {24'd0, muxsel}, 32'h0000_0000);
    check("abort_err_hold", {31'd0, err}, 32'd0);
    repeat (3) tick();
    check("abort_no_done", {31'd0, done}, 32'd0);

`ifdef MUX_CFG_PARITY_EN
    // 0x0001 has odd weight, so parity bit 1 commits and parity bit 0 errors.
    load(16'h0001, 1'b0, 1'b1, 1'b0);
    check("par_ok_msel", {24'd0, msel}, 32'h0000_0001);
    load(16'h0001, 1'b0, 1'b0, 1'b0);
    repeat (2) tick();
    check("err_sticky", {31'd0, err}, 32'd1);
    // The next accepted start clears err (checked inside load).
    load(16'h00FF, 1'b0, par_of(16'h00FF), 1'b0);
`endif

    // Reset in the middle of SHIFT, after 10 bits.
    do_start();
    for (int k = 0; k < 10; k++) send_bit(1'b1);
    bit_valid = 1'b0;
    reset     = 1'b1;
    tick();
    reset     = 1'b0;
    last_cfg  = 16'h0000;
    check("midrst_msel", {24'd0, msel}, 32'd0);
    check("midrst_muxsel", {24'd0, muxsel}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_ready", {31'd0, bit_ready}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_err", {31'd0, err}, 32'd0);
    load(16'hC3A5, 1'b0, par_of(16'hC3A5), 1'b0);

    repeat (3) tick();
    check("sb_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
